// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length/data/checksum framed byte
// stream, writes little-endian words to IMEM and releases the core once the image checks out.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [7:0]  csum;
    logic [15:0] nwords;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic        hs;
    logic [15:0] len_in;
    logic        len_ok;
    logic        last_word;
    logic        load;

    assign hs        = rx_valid && rx_ready;
    assign len_in    = {rx_data, len_lo};
    assign len_ok    = (len_in != 16'd0) && ({1'b0, len_in} <= MAX_N);
    assign last_word = (byte_cnt == 2'd3) && ((word_idx + 16'd1) == nwords);
    assign load      = start && ((state == IDLE) || (state == RUN) || (state == ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = len_ok ? DATA : ERR;
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs && last_word) state_nxt = CSUM;
            end
            CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = (rx_data == csum) ? RUN : ERR;
            end
            RUN: begin
                done = 1'b1;
                if (start) state_nxt = LEN_LO;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = LEN_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completed words are copied out of the shift register so the next byte can land immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we      <= 1'b0;
            im_addr    <= 32'd0;
            im_wdata   <= 32'd0;
            core_rst_n <= 1'b0;
            err_code   <= 2'b00;
            len_lo     <= 8'd0;
            csum       <= 8'd0;
            nwords     <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            shreg      <= 24'd0;
        end else begin
            im_we      <= 1'b0;
            core_rst_n <= (state_nxt == RUN);
            if (load) begin
                word_idx <= 16'd0;
                csum     <= 8'd0;
                err_code <= 2'b00;
                byte_cnt <= 2'd0;
            end
            if (hs) begin
                case (state)
                    LEN_LO: begin
                        len_lo <= rx_data;
                        csum   <= csum ^ rx_data;
                    end
                    LEN_HI: begin
                        nwords <= len_in;
                        csum   <= csum ^ rx_data;
                        if (!len_ok) err_code <= 2'b01;
                    end
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {rx_data, shreg[23:8]};
                        if (byte_cnt == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= {rx_data, shreg};
                            im_addr  <= {{(30-ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                    CSUM: begin
                        if (rx_data != csum) err_code <= 2'b10;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  fr[$];

    typedef struct {
        logic [7:0] b [0:10];
        int         nb;
        int         maxgap;
        logic       edone;
        logic [1:0] ecode;
        int         ew;
    } vec_t;

    vec_t tbl [0:5];
    logic [7:0] good [0:10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                8'h93, 8'h05, 8'h20, 8'h00, 8'hB2};

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always @(negedge clk) begin
        if (im_we) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start();
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_rx_ready", rx_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        chk("byte_rx_ready", rx_ready, 1);
        @(negedge clk);
    endtask

    // Reference model works on the whole frame in fr: length rule, word layout, XOR check.
    task automatic run_frame(input int maxgap, input bit skip_start, input int start_at,
                             output logic o_done, output logic [1:0] o_code, output int o_nw);
        int          n, consume, ecode, ew;
        logic [7:0]  x;
        logic [31:0] ed;
        n = int'({fr[1], fr[0]});
        if (n == 0 || n > 256) begin
            ecode = 1; consume = 2; ew = 0;
        end else begin
            consume = 4 * n + 3; ew = n; x = 8'h00;
            for (int i = 0; i < 4 * n + 2; i++) x = x ^ fr[i];
            ecode = (x == fr[4 * n + 2]) ? 0 : 2;
        end
        wa_q.delete();
        wd_q.delete();
        if (!skip_start) do_start();
        for (int i = 0; i < consume; i++) begin
            if (i == start_at) begin
                rx_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("start_in_busy_ready", rx_ready, 1);
                chk("start_in_busy_busy", busy, 1);
            end
            send_byte(fr[i], int'($urandom_range(0, maxgap)));
        end
        rx_valid = 1'b0;
        chk("end_done", done, (ecode == 0));
        chk("end_error", error, (ecode != 0));
        chk("end_err_code", err_code, ecode);
        chk("end_core_rst_n", core_rst_n, (ecode == 0));
        chk("end_rx_ready", rx_ready, 0);
        chk("end_busy", busy, 0);
        chk("nwrites", wa_q.size(), ew);
        for (int i = 0; i < ew; i++) begin
            if (i < wa_q.size()) begin
                ed = {fr[4*i+5], fr[4*i+4], fr[4*i+3], fr[4*i+2]};
                chk("waddr", wa_q[i], 4 * i);
                chk("wdata", wd_q[i], ed);
            end
        end
        o_done = done;
        o_code = err_code;
        o_nw   = wa_q.size();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       d;
        logic [1:0] c;
        int         nw, n, mode;
        logic [7:0] x, bt;

        for (int i = 0; i < 6; i++) begin
            tbl[i].b = good; tbl[i].nb = 11; tbl[i].maxgap = 0;
            tbl[i].edone = 1'b1; tbl[i].ecode = 2'b00; tbl[i].ew = 2;
        end
        tbl[1].b[10] = 8'hB3; tbl[1].edone = 1'b0; tbl[1].ecode = 2'b10;
        tbl[2].b[0] = 8'h00; tbl[2].b[1] = 8'h00; tbl[2].nb = 2;
        tbl[2].edone = 1'b0; tbl[2].ecode = 2'b01; tbl[2].ew = 0;
        tbl[3].b[0] = 8'h01; tbl[3].b[1] = 8'h01; tbl[3].nb = 2;
        tbl[3].edone = 1'b0; tbl[3].ecode = 2'b01; tbl[3].ew = 0;
        tbl[4].maxgap = 5;

        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fr.delete();
            for (int j = 0; j < tbl[i].nb; j++) fr.push_back(tbl[i].b[j]);
            run_frame(tbl[i].maxgap, 1'b0, -1, d, c, nw);
            chk("tbl_done", d, tbl[i].edone);
            chk("tbl_code", c, tbl[i].ecode);
            chk("tbl_nw", nw, tbl[i].ew);
            if (i == 0) begin
                chk("good_a0", wa_q[0], 32'h0);
                chk("good_d0", wd_q[0], 32'h00100513);
                chk("good_a1", wa_q[1], 32'h4);
                chk("good_d1", wd_q[1], 32'h00200593);
            end
        end

        // Start in RUN re-asserts core reset and re-enters the length phase.
        do_start();
        chk("rerun_core_rst_n", core_rst_n, 0);
        chk("rerun_busy", busy, 1);
        chk("rerun_done", done, 0);
        fr.delete();
        foreach (good[j]) fr.push_back(good[j]);
        run_frame(1, 1'b1, -1, d, c, nw);
        chk("rerun_final_done", d, 1);

        // Start pulsed mid-DATA must not disturb the frame.
        run_frame(0, 1'b0, 4, d, c, nw);
        chk("start_data_done", d, 1);
        chk("start_data_nw", nw, 2);

        // Reset mid-DATA with a write strobe pending.
        do_start();
        for (int i = 0; i < 6; i++) send_byte(good[i], 0);
        rx_valid = 1'b0;
        chk("pre_rst_we", im_we, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        wa_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_writes", wa_q.size(), 0);
        chk("post_rst_ready", rx_ready, 0);
        chk("post_rst_busy", busy, 0);
        run_frame(2, 1'b0, -1, d, c, nw);
        chk("post_rst_done", d, 1);

        for (int k = 0; k < 20; k++) begin
            fr.delete();
            mode = int'($urandom_range(0, 7));
            if (mode == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 600));
            else n = int'($urandom_range(1, 6));
            fr.push_back(n[7:0]);
            fr.push_back(n[15:8]);
            if (n >= 1 && n <= 256) begin
                x = n[7:0] ^ n[15:8];
                for (int j = 0; j < 4 * n; j++) begin
                    bt = 8'($urandom);
                    fr.push_back(bt);
                    x = x ^ bt;
                end
                if (mode == 1) x = x ^ 8'($urandom_range(1, 255));
                fr.push_back(x);
            end
            run_frame(3, 1'b0, -1, d, c, nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It holds the core in reset and accepts a framed byte stream on a valid/ready interface. It assembles the stream into little-endian 32-bit words, writes them to consecutive instruction-memory word addresses, and checks an XOR checksum. It releases the core's reset only after a complete, valid image has been written.

## Interface
Parameters:
- ADDR_W, default 8: instruction-memory word-address width; maximum image size is 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, RUN or ERR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready on a clock edge.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  32  byte address of the write, equal to 4 × word index.
- im_wdata  out  32  word to write.
- core_rst_n  out  1  registered active-low reset to the core.
- busy  out  1  high in LEN_LO, LEN_HI, DATA and CSUM.
- done  out  1  high in RUN.
- error  out  1  high in ERR.
- err_code  out  2  01 = bad length, 10 = checksum mismatch, 00 otherwise.

## Operation
- Frame format, in order:
  - LEN_LO, then LEN_HI: 16-bit word count N, little-endian.
  - 4·N data bytes; each word is little-endian, so the first byte lands in [7:0].
  - One checksum byte.
- The checksum is the XOR of every preceding frame byte, including both length bytes.
- States and transitions:
  - IDLE: on start, go to LEN_LO.
  - LEN_LO: on handshake, go to LEN_HI.
  - LEN_HI: on handshake, go to DATA if 1 ≤ N ≤ 2**ADDR_W. Otherwise go to ERR with err_code=01.
  - DATA: after the 4·N-th byte handshake, go to CSUM.
  - CSUM: on handshake, go to RUN if the byte equals the running XOR. Otherwise go to ERR with err_code=10.
  - RUN and ERR: on start, go to LEN_LO and clear the word index, XOR accumulator and err_code.
- rx_ready is 1 exactly in LEN_LO, LEN_HI, DATA and CSUM, and 0 elsewhere.
- start is ignored while busy.
- Word assembly:
  - A 2-bit byte counter and a shift register collect bytes.
  - On the 4th byte of a word, the completed word is copied into the im_wdata register.
  - At the same edge, im_addr is set from the current word index, and the word index increments.
  - Because of the copy, the next byte may arrive the following cycle without corrupting the pending write.
- core_rst_n:
  - 0 in every state except RUN.
  - Driven from a flop, so it is glitch-free and its release is synchronous to clk.
  - Entering LEN_LO from RUN re-asserts it (drives it to 0).
- Error handling:
  - Words already written before an ERR are not rolled back.
  - The core stays in reset until a later load succeeds.
- The loader never reads or clears instruction memory. Words at indices ≥ N keep their old contents.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - State: IDLE.
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - core_rst_n=0, busy=0, done=0, error=0, err_code=00.
- start → LEN_LO: rx_ready=1 in the cycle after the start edge.
- Byte rate: one byte per cycle maximum. rx_valid gaps of any length are allowed and must not change the result.
- Write strobe: im_we is high for exactly the one cycle after the 4th-byte handshake of each word, with im_addr and im_wdata valid in that same cycle. Exactly N strobes per frame.
- Checksum: after the checksum-byte handshake, the next cycle shows either done=1 with core_rst_n=1, or error=1 with err_code set.
- Reset mid-frame: takes effect immediately.
  - All outputs return to their reset values.
  - Any pending im_we is dropped.
  - A fresh start is then required.
- Address width: im_addr[31:ADDR_W+2]=0 and im_addr[1:0]=0 always. The word index never wraps, because N is bounded.

## Test plan
- Good load, ADDR_W=8: start, then bytes 02 00 13 05 10 00 93 05 20 00 B2.
  - im_we (addr 0x0, data 0x00100513), then im_we (addr 0x4, data 0x00200593).
  - Then done=1 and core_rst_n=1 one cycle after the B2 handshake.
- Bad checksum: same frame ending in B3.
  - Both writes still occur.
  - error=1, err_code=10, core_rst_n stays 0, rx_ready=0.
- Bad length: frame 00 00 → ERR with err_code=01 and no im_we. Repeat with 01 01 (N=257 > 256) → ERR with err_code=01.
- Flow control: the good-load frame with random 0–5 cycle rx_valid gaps, then fully back-to-back → identical writes, exactly 2 strobes, done=1.
- Reset mid-DATA: pulse rst_n low after 6 bytes have been accepted.
  - All outputs take their reset values during the low phase; no further im_we.
  - A subsequent start plus the good-load frame succeeds.
- Start semantics:
  - start pulsed in DATA is ignored.
  - start in RUN drops core_rst_n to 0 in the next cycle and raises busy; a full reload then returns to RUN.
